// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with issue-time scoreboard.
// Two combinational read ports, one synchronous write port, and a per-register
// busy bit set at reservation and cleared by the write that resolves it.
// The zero register (XZR) sits at index NREGS-1: it reads 0, ignores writes and
// is never marked busy.  Reads of addresses >= NREGS also return 0 / not busy.
// Optional build macro: REGFILE_BYPASS_EN -- forward an accepted same-cycle
// write to a matching read port and mask its busy flag.

// Per-read-port lookup: address range check, data and busy select.
module regfile_sb_rdport #(
  parameter int DW    = 64,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic [AW-1:0]              ra,
  input  logic [NREGS-1:0][DW-1:0]   regs,
  input  logic [NREGS-1:0]           busy,
  output logic [DW-1:0]              rd,
  output logic                       bsy
);
  logic addr_ok;
  assign addr_ok = (32'(ra) < NREGS) && (32'(ra) != NREGS - 1);

  // XZR and out-of-range addresses read as zero and never report busy
  always_comb begin
    rd  = '0;
    bsy = 1'b0;
    if (addr_ok) begin
      rd  = regs[ra];
      bsy = busy[ra];
    end
  end
endmodule

module regfile_sb #(
  parameter int DW    = 64,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          we3,
  input  logic [AW-1:0] wa3,
  input  logic [DW-1:0] wd3,
  input  logic          rsv_en,
  input  logic [AW-1:0] rsv_addr,
  output logic          busy1,
  output logic          busy2,
  output logic          stall,
  output logic [AW:0]   npend
);
  localparam int NRP = 2;
  localparam int XZR = NREGS - 1;

  logic [NREGS-1:0][DW-1:0] regs_q, regs_d;
  logic [NREGS-1:0]         busy_q, busy_d;
  logic [AW:0]              npend_q, npend_d;
  logic                     wr_ok, rsv_ok;

  logic [NRP-1:0][AW-1:0]   ra_v;
  logic [NRP-1:0][DW-1:0]   rd_raw, rd_v;
  logic [NRP-1:0]           bsy_raw, bsy_v;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < NREGS) && (32'(a) != XZR);
  endfunction

  assign wr_ok  = we3    && addr_ok(wa3);
  assign rsv_ok = rsv_en && addr_ok(rsv_addr);

  // Next state: write data, scoreboard (clear on write, set wins), popcount
  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_q;
    npend_d = '0;
    if (wr_ok) begin
      regs_d[wa3] = wd3;
      busy_d[wa3] = 1'b0;
    end
    if (rsv_ok) busy_d[rsv_addr] = 1'b1;
    for (int i = 0; i < NREGS; i++) npend_d = npend_d + (AW+1)'(busy_d[i]);
  end

  // State registers; reset loads regs[i]=i (XZR=0) and clears the scoreboard
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= (i == XZR) ? '0 : DW'(i);
      busy_q  <= '0;
      npend_q <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      npend_q <= npend_d;
    end
  end

  assign ra_v = {ra2, ra1};

  for (genvar p = 0; p < NRP; p++) begin : g_rp
    regfile_sb_rdport #(.DW(DW), .NREGS(NREGS), .AW(AW)) u_rp (
      .ra   (ra_v[p]),
      .regs (regs_q),
      .busy (busy_q),
      .rd   (rd_raw[p]),
      .bsy  (bsy_raw[p])
    );

`ifdef REGFILE_BYPASS_EN
    logic byp;
    // Forward an accepted write to a matching port; never while in reset
    always_comb begin
      byp        = wr_ok && (ra_v[p] == wa3) && !reset;
      rd_v[p]    = byp ? wd3 : rd_raw[p];
      bsy_v[p]   = byp ? 1'b0 : bsy_raw[p];
    end
`else
    // No forwarding: the write becomes visible after the edge
    always_comb begin
      rd_v[p]  = rd_raw[p];
      bsy_v[p] = bsy_raw[p];
    end
`endif
  end

  assign rd1   = rd_v[0];
  assign rd2   = rd_v[1];
  assign busy1 = bsy_v[0];
  assign busy2 = bsy_v[1];
  assign stall = busy1 | busy2;
  assign npend = npend_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Randomized + directed bench for regfile_sb against an array-based model.
module tb_regfile_sb;
  localparam int N  = 32;
  localparam int NB = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ra1, ra2, wa3, rsv_addr;
  logic [63:0] rd1, rd2, wd3;
  logic        we3, rsv_en, busy1, busy2, stall;
  logic [5:0]  npend;

  logic [4:0]  b_ra1, b_ra2, b_wa3, b_rsv_addr;
  logic [63:0] b_rd1, b_rd2, b_wd3;
  logic        b_we3, b_rsv_en, b_busy1, b_busy2, b_stall;
  logic [5:0]  b_npend;

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] m_regs [N];
  bit          m_busy [N];

  always #5 clk = ~clk;

  regfile_sb u_dut (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we3(we3), .wa3(wa3), .wd3(wd3), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy1(busy1), .busy2(busy2), .stall(stall), .npend(npend));

  regfile_sb #(.NREGS(NB)) u_dut24 (
    .clk(clk), .reset(reset), .ra1(b_ra1), .ra2(b_ra2), .rd1(b_rd1), .rd2(b_rd2),
    .we3(b_we3), .wa3(b_wa3), .wd3(b_wd3), .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
    .busy1(b_busy1), .busy2(b_busy2), .stall(b_stall), .npend(b_npend));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_regs[i] = (i == N - 1) ? 64'd0 : 64'(i);
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic bit byp_hit(input int a);
`ifdef REGFILE_BYPASS_EN
    return !reset && we3 && (int'(wa3) < N - 1) && (a == int'(wa3));
`else
    return 1'b0 && (a == 0);
`endif
  endfunction

  function automatic logic [63:0] exp_rd(input int a);
    if (a >= N - 1) return 64'd0;
    if (byp_hit(a)) return wd3;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a >= N - 1) return 1'b0;
    if (byp_hit(a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int exp_npend();
    int c = 0;
    foreach (m_busy[i]) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic check_comb(input string pfx);
    logic eb1, eb2;
    eb1 = exp_busy(int'(ra1));
    eb2 = exp_busy(int'(ra2));
    chk({pfx, "_rd1"},   rd1,   exp_rd(int'(ra1)));
    chk({pfx, "_rd2"},   rd2,   exp_rd(int'(ra2)));
    chk({pfx, "_busy1"}, 64'(busy1), 64'(eb1));
    chk({pfx, "_busy2"}, 64'(busy2), 64'(eb2));
    chk({pfx, "_stall"}, 64'(stall), 64'(eb1 | eb2));
    chk({pfx, "_npend"}, 64'(npend), 64'(exp_npend()));
  endtask

  // Advance one clock: model applies the inputs held across the edge
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      if (we3 && int'(wa3) < N - 1) begin
        m_regs[wa3] = wd3;
        m_busy[wa3] = 1'b0;
      end
      if (rsv_en && int'(rsv_addr) < N - 1) m_busy[rsv_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic rv, input logic [4:0] rva,
                       input logic [4:0] a1, input logic [4:0] a2);
    we3 = we; wa3 = wa; wd3 = wd; rsv_en = rv; rsv_addr = rva; ra1 = a1; ra2 = a2;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 5, 31);
    b_we3 = 0; b_wa3 = 0; b_wd3 = 0; b_rsv_en = 0; b_rsv_addr = 0; b_ra1 = 0; b_ra2 = 0;
    model_reset();
    #1;
    check_comb("inrst");
    chk("inrst_rd1_const", rd1, 64'd5);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    // Reset values after release
    chk("rst_rd1", rd1, 64'd5);
    chk("rst_rd2", rd2, 64'd0);
    chk("rst_npend", 64'(npend), 64'd0);
    check_comb("rst");

    // Write to XZR is discarded
    drive(1, 31, 64'hFF, 0, 0, 31, 5);
    #1 check_comb("xzrw");
    tick();
    drive(0, 0, 0, 0, 0, 31, 31);
    #1;
    chk("xzr_rd1", rd1, 64'd0);
    chk("xzr_busy1", 64'(busy1), 64'd0);
    check_comb("xzr");

    // Reserve 7, then resolve with a write
    drive(0, 0, 0, 1, 7, 7, 0);
    #1 check_comb("rsv7a");
    tick();
    drive(0, 0, 0, 0, 0, 7, 0);
    #1;
    chk("rsv7_busy1", 64'(busy1), 64'd1);
    chk("rsv7_stall", 64'(stall), 64'd1);
    chk("rsv7_npend", 64'(npend), 64'd1);
    drive(1, 7, 64'h1234, 0, 0, 7, 0);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("w7_rd1_byp", rd1, 64'h1234);
    chk("w7_busy1_byp", 64'(busy1), 64'd0);
`else
    chk("w7_rd1_old", rd1, 64'd7);
    chk("w7_busy1_old", 64'(busy1), 64'd1);
`endif
    check_comb("w7");
    tick();
    drive(0, 0, 0, 0, 0, 7, 0);
    #1;
    chk("w7n_rd1", rd1, 64'h1234);
    chk("w7n_busy1", 64'(busy1), 64'd0);
    chk("w7n_npend", 64'(npend), 64'd0);

    // Same-cycle reserve and write on an already reserved register: set wins
    drive(0, 0, 0, 1, 3, 3, 0);
    tick();
    drive(1, 3, 64'hABCD, 1, 3, 0, 0);
    #1 check_comb("rw3pre");
    chk("rw3_npend_pre", 64'(npend), 64'd1);
    tick();
    drive(0, 0, 0, 0, 0, 3, 0);
    #1;
    chk("rw3_rd1", rd1, 64'hABCD);
    chk("rw3_busy1", 64'(busy1), 64'd1);
    chk("rw3_npend", 64'(npend), 64'd1);
    check_comb("rw3");

    // Non-reserved write leaves the scoreboard alone
    drive(1, 9, 64'h99, 0, 0, 9, 3);
    tick();
    drive(0, 0, 0, 0, 0, 9, 3);
    #1;
    chk("nr9_rd1", rd1, 64'h99);
    chk("nr9_npend", 64'(npend), 64'd1);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      logic [4:0] w, a1, a2;
      w  = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), w, {$urandom, $urandom},
            1'($urandom_range(0, 99) < 40), 5'($urandom_range(0, 31)), a1, a2);
      #1 check_comb("rnd");
      tick();
    end

    // Async reset mid-cycle after reserving 1,2,3
    drive(1, 1, 64'h55, 0, 0, 1, 2);
    tick();
    drive(0, 0, 0, 1, 1, 1, 2); tick();
    drive(0, 0, 0, 1, 2, 1, 2); tick();
    drive(0, 0, 0, 1, 3, 1, 2); tick();
    drive(0, 0, 0, 0, 0, 1, 2);
    #1 chk("prerst_npend_nz", 64'(npend != 0), 64'd1);
    #1 reset = 1'b1;
    model_reset();
    #1;
    chk("arst_npend", 64'(npend), 64'd0);
    chk("arst_rd1", rd1, 64'd1);
    chk("arst_busy1", 64'(busy1), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    // Write and reservation while reset is held have no effect
    drive(1, 1, 64'hDEAD, 1, 2, 1, 2);
    #1 check_comb("hold");
    tick();
    #1;
    chk("hold_rd1", rd1, 64'd1);
    chk("hold_npend", 64'(npend), 64'd0);
    check_comb("hold2");
    drive(0, 0, 0, 0, 0, 1, 2);
    reset = 1'b0;
    #1 check_comb("rel");

    // 24-register instance: out-of-range and XZR handling
    b_we3 = 1; b_wa3 = 25; b_wd3 = 64'h77; b_rsv_en = 1; b_rsv_addr = 25;
    @(posedge clk); @(negedge clk);
    b_wa3 = 23; b_rsv_addr = 23;
    @(posedge clk); @(negedge clk);
    b_wa3 = 22; b_wd3 = 64'h2222; b_rsv_en = 0;
    @(posedge clk); @(negedge clk);
    b_we3 = 0; b_ra1 = 25; b_ra2 = 23;
    #1;
    chk("n24_rd25", b_rd1, 64'd0);
    chk("n24_rd23", b_rd2, 64'd0);
    chk("n24_busy25", 64'(b_busy1), 64'd0);
    chk("n24_npend", 64'(b_npend), 64'd0);
    b_ra1 = 22; b_ra2 = 10;
    #1;
    chk("n24_rd22", b_rd1, 64'h2222);
    chk("n24_rd10", b_rd2, 64'd10);
    chk("n24_stall", 64'(b_stall), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DW, default 64, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, number of architectural registers (2..64).
REQ-003 SHALL have parameter AW, default $clog2(NREGS), address width.
REQ-004 SHALL fix the zero register XZR at index NREGS-1.
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- ra1, ra2  in  AW  read addresses.
- rd1, rd2  out  DW  read data.
- we3  in  1  write enable.
- wa3  in  AW  write address.
- wd3  in  DW  write data.
- rsv_en  in  1  reserve destination at issue.
- rsv_addr  in  AW  register to reserve.
- busy1, busy2  out  1  ra1 / ra2 has an unresolved pending write.
- stall  out  1  busy1 | busy2.
- npend  out  AW+1  count of reserved registers.

Function
REQ-006 SHALL read rd1/rd2 combinationally, with zero cycles of latency.
REQ-007 SHALL return 0 on a read of XZR, or of any address >= NREGS.
REQ-008 SHALL write wd3 to regs[wa3] on the rising clk edge when we3=1, wa3!=XZR and wa3<NREGS; any other write SHALL be discarded with no state change.
REQ-009 SHALL keep a scoreboard busy[NREGS-1:0].
- rsv_en=1 with a valid rsv_addr that is not XZR: set busy[rsv_addr] at the edge.
- A write accepted by REQ-008: clear busy[wa3] at the edge.
REQ-010 SHALL let set win when a reservation and a write target the same register in the same cycle, so busy stays 1.
REQ-011 SHALL never set busy[XZR]; a reservation of XZR or of an out-of-range address SHALL be ignored.
REQ-012 SHALL accept a write to a non-reserved register normally; the scoreboard SHALL NOT change.
REQ-013 SHALL drive busy1 = busy[ra1], except per REQ-020; busy2 likewise.
REQ-014 SHALL drive busy1/busy2 to 0 for XZR or out-of-range addresses.
REQ-015 SHALL hold npend equal to the population count of busy as registered state, updated in the same edge as busy; npend SHALL NOT wrap.
REQ-016 SHALL make stall purely combinational from busy1 and busy2.

Reset
REQ-017 SHALL, on reset assertion and regardless of clk:
- set regs[i]=i for every i<NREGS-1, and regs[XZR]=0;
- clear busy to 0 and npend to 0.
REQ-018 SHALL give reset priority over any concurrent write or reservation, including one in the same cycle as a mid-operation assertion.
REQ-019 SHALL, while reset is held, drive rd1/rd2 to the reset register values, with busy1=busy2=stall=0.

Configuration
REQ-020 SHALL define REGFILE_BYPASS_EN as follows.
- Defined: when we3=1, wa3!=XZR, wa3<NREGS and ra1==wa3, rd1=wd3 in the same cycle and busy1=0; rd2/busy2 likewise.
- Undefined: rd shows the old value until after the edge; busy is per REQ-013 with no override.

Verification
REQ-021 SHALL cover these directed scenarios:
- Reset, then read ra1=5, ra2=31 (NREGS=32) -> rd1=5, rd2=0, npend=0.
- we3=1, wa3=31, wd3=0xFF; next cycle read 31 -> rd=0; busy unchanged.
- rsv_en on reg 7; one cycle later ra1=7 -> busy1=1, stall=1, npend=1. Then we3 wa3=7 wd3=0x1234.
  - With BYPASS_EN: rd1=0x1234 and busy1=0 in that cycle.
  - Without BYPASS_EN: busy1=1 that cycle, then rd1=0x1234 and busy1=0 next cycle.
- Same-cycle rsv_en rsv_addr=3 and we3 wa3=3 -> after the edge regs[3] is updated, busy[3]=1, npend unchanged.
- Reserve regs 1,2,3 on consecutive cycles, then assert reset asynchronously mid-cycle -> npend=0, busy all 0 and regs[1]=1 immediately, without waiting for a clk edge.
- NREGS=24 instance: write to 25 ignored; read of 25 returns 0; XZR=23 reads 0.
